mdu_iter: RTL

- Parametrised iterative multiply/divide unit with HI/LO result registers for the pipelined MIPS core.
- Sits beside the Execute-stage ALU and serves MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Produces a stall request for the hazard unit while an operation is in flight.
- Generalises the single-cycle ALU to WIDTH-bit operands with a multi-cycle start/busy/done handshake, a flush and signed/unsigned modes.

---
 rtl/mdu_iter_if.sv | 30 +++
 rtl/mdu_iter.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mdu_iter_if.sv
// Handshake and result bundle between the Execute stage and the iterative MDU.
// The divz flag exists only when MDU_DIV0_FAST_EN is defined.
interface mdu_iter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             flush;
  logic             hilo_rd;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MDU_DIV0_FAST_EN
  logic             divz;

  modport master (output start, op, srca, srcb, flush, hilo_rd,
                  input  busy, done, stall, hi, lo, divz);
  modport slave  (input  start, op, srca, srcb, flush, hilo_rd,
                  output busy, done, stall, hi, lo, divz);
`else
  modport master (output start, op, srca, srcb, flush, hilo_rd,
                  input  busy, done, stall, hi, lo);
  modport slave  (input  start, op, srca, srcb, flush, hilo_rd,
                  output busy, done, stall, hi, lo);
`endif
endinterface

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply / restoring divide unit with HI/LO registers.
// Optional MDU_DIV0_FAST_EN: one-cycle divide-by-zero completion plus a divz flag.
module mdu_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  mdu_iter_if.slave  bus
);
  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           state;
  logic [WIDTH-1:0] aMag, bMag, hiReg, loReg;
  logic [AW-1:0]    acc;
  logic [CW-1:0]    cnt;
  logic             negA, negB, isDivOp, busyReg, doneReg;
`ifdef MDU_DIV0_FAST_EN
  logic             divzReg;
`endif

  logic             signedOp, srcaNeg, srcbNeg, lastIter, bZero, negRes;
  logic [WIDTH-1:0] srcaAbs, srcbAbs, quoFix, remFix;
  logic [WIDTH:0]   mulSum, remShift, divDiff;
  logic [AW-1:0]    mulNext, divNext, prodFix;

  // Operand magnitudes, one iteration step of each algorithm, and sign fix-up
  always_comb begin
    signedOp = !bus.op[2] && !bus.op[0];
    srcaNeg  = signedOp && bus.srca[WIDTH-1];
    srcbNeg  = signedOp && bus.srcb[WIDTH-1];
    srcaAbs  = srcaNeg ? -bus.srca : bus.srca;
    srcbAbs  = srcbNeg ? -bus.srcb : bus.srcb;

    mulSum   = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, aMag} : (WIDTH+1)'(0));
    mulNext  = {mulSum, acc[WIDTH-1:1]};

    remShift = acc[AW-1:WIDTH-1];
    divDiff  = remShift - {1'b0, bMag};
    divNext  = divDiff[WIDTH] ? {remShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                              : {divDiff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

    lastIter = (cnt == CW'(WIDTH - 1));
    bZero    = (bMag == '0);
    negRes   = negA ^ negB;
    prodFix  = negRes ? -acc : acc;
    // A zero divisor leaves |dividend| as remainder; the dividend-sign rule restores raw srca
    quoFix   = bZero ? '1 : (negRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    remFix   = negA ? -acc[AW-1:WIDTH] : acc[AW-1:WIDTH];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      hiReg   <= '0;
      loReg   <= '0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      aMag    <= '0;
      bMag    <= '0;
      negA    <= 1'b0;
      negB    <= 1'b0;
      isDivOp <= 1'b0;
`ifdef MDU_DIV0_FAST_EN
      divzReg <= 1'b0;
`endif
    end else begin
      doneReg <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start && !bus.flush) begin
            if (!bus.op[2]) begin
              aMag    <= srcaAbs;
              bMag    <= srcbAbs;
              negA    <= srcaNeg;
              negB    <= srcbNeg;
              isDivOp <= bus.op[1];
              cnt     <= '0;
              busyReg <= 1'b1;
              acc     <= {WIDTH'(0), (bus.op[1] ? srcaAbs : srcbAbs)};
              state   <= bus.op[1] ? DIV : MUL;
`ifdef MDU_DIV0_FAST_EN
              divzReg <= 1'b0;
              if (bus.op[1] && (bus.srcb == '0)) begin
                acc   <= {srcaAbs, WIDTH'(0)};
                state <= FIX;
              end
`endif
            end else if (!bus.op[1]) begin
              if (bus.op[0]) loReg <= bus.srca;
              else           hiReg <= bus.srca;
            end
          end
        end
        MUL, DIV: begin
          if (bus.flush) begin
            state   <= IDLE;
            busyReg <= 1'b0;
          end else begin
            acc <= (state == MUL) ? mulNext : divNext;
            cnt <= cnt + CW'(1);
            if (lastIter) state <= FIX;
          end
        end
        FIX: begin
          state   <= IDLE;
          busyReg <= 1'b0;
          if (!bus.flush) begin
            if (isDivOp) begin
              hiReg <= remFix;
              loReg <= quoFix;
            end else begin
              {hiReg, loReg} <= prodFix;
            end
            doneReg <= 1'b1;
`ifdef MDU_DIV0_FAST_EN
            divzReg <= isDivOp && bZero;
`endif
          end
        end
      endcase
    end
  end

  assign bus.busy  = busyReg;
  assign bus.done  = doneReg;
  assign bus.hi    = hiReg;
  assign bus.lo    = loReg;
  assign bus.stall = busyReg & (bus.start | bus.hilo_rd);
`ifdef MDU_DIV0_FAST_EN
  assign bus.divz  = divzReg;
`endif

endmodule
